// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   OP_*    : operation encodings as presented on the op port
//   S_*     : sequencer state encoding
//   ITER    : number of CALC iterations (one per operand bit)
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide engine.
// Ports:
//   i_acc_hi  : upper half of the accumulator (partial product / remainder)
//   i_lsb_in  : multiply: current multiplier LSB; divide: next dividend bit
//   i_operand : multiplicand (multiply) or divisor (divide), magnitudes
//   i_is_div  : selects restoring-divide step instead of shift-add step
//   o_acc_hi  : next upper half of the accumulator
//   o_qbit    : divide: quotient bit; multiply: product bit leaving the
//               upper half and entering the lower half
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic             i_lsb_in,
    input  logic [WIDTH-1:0] i_operand,
    input  logic             i_is_div,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic             o_qbit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic           w_ge;

    // Multiply: add the multiplicand when the multiplier bit is set; the sum
    // is then shifted right one place across the whole accumulator.
    assign w_sum = {1'b0, i_acc_hi} + (i_lsb_in ? {1'b0, i_operand} : '0);

    // Divide: the remainder is shifted left with the next dividend bit. A
    // plain compare avoids the borrow-bit ambiguity of a (WIDTH+1)-bit
    // subtract when the divisor is zero.
    assign w_rem_sh = {i_acc_hi, i_lsb_in};
    assign w_ge     = (w_rem_sh >= {1'b0, i_operand});

    always_comb begin
        o_acc_hi = w_sum[WIDTH:1];
        o_qbit   = w_sum[0];
        if (i_is_div) begin
            o_acc_hi = w_ge ? WIDTH'(w_rem_sh - {1'b0, i_operand})
                            : w_rem_sh[WIDTH-1:0];
            o_qbit   = w_ge;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   i_start, i_op       : start request and operation (MULT/MULTU/DIV/DIVU)
//   i_a, i_b            : rs / rt operands, sampled with an accepted start
//   i_cancel            : pipeline flush, aborts an operation in flight
//   i_hi_we, i_lo_we    : MTHI / MTLO write enables (honoured only in IDLE)
//   i_wdata             : MTHI / MTLO data
//   o_busy              : operation in flight
//   o_done              : one-cycle pulse when HI/LO hold a new result
//   o_div_zero          : sticky divide-by-zero flag, cleared on next start
//   o_hi, o_lo          : architectural HI / LO registers
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cancel,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_lo;   // negate product / quotient
    logic               r_neg_hi;   // negate remainder (sign of dividend)
    logic               r_b_zero;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    op_e                w_op;
    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_step_hi;
    logic               w_step_bit;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op     = op_e'(i_op);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
    assign w_abs_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply shifts the accumulator right (multiplier consumed from bit 0);
    // divide shifts it left (dividend consumed from the top of the low half).
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc_hi  (r_acc[2*WIDTH-1:WIDTH]),
        .i_lsb_in  (r_is_div ? r_acc[WIDTH-1] : r_acc[0]),
        .i_operand (r_opnd),
        .i_is_div  (r_is_div),
        .o_acc_hi  (w_step_hi),
        .o_qbit    (w_step_bit)
    );

    assign w_step_lo = r_is_div ? {r_acc[WIDTH-2:0], w_step_bit}
                                : {w_step_bit, r_acc[WIDTH-1:1]};

    // Sign correction. With a zero divisor the engine leaves |a| in the
    // remainder; giving it the dividend's sign reproduces a exactly.
    assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
    assign w_quot_fix = r_b_zero ? '1
                      : (r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH]
                                 : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_b_zero   <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_hi_we) r_hi <= i_wdata;
                    if (i_lo_we) r_lo <= i_wdata;
                    if (i_start && !i_cancel) begin
                        r_is_div   <= w_is_div;
                        r_neg_lo   <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_neg_hi   <= w_signed && w_is_div && i_a[WIDTH-1];
                        r_b_zero   <= w_is_div && (i_b == '0);
                        r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
                        r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                        r_count    <= '0;
                        r_div_zero <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (i_cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= {w_step_hi, w_step_lo};
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!i_cancel) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_div_zero <= r_b_zero;
                        r_done     <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk;
    logic        reset_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_cancel;
    logic        i_hi_we;
    logic        i_lo_we;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_div_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   done_count;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_cancel   (i_cancel),
        .i_hi_we    (i_hi_we),
        .i_lo_we    (i_lo_we),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        done_count = 0;
        forever begin
            @(negedge clk);
            if (reset_n && o_done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", o_hi, e.hi);
                    check("result_lo", o_lo, e.lo);
                    check("result_div_zero", 32'(o_div_zero), 32'(e.dz));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ez);
        exp_t e;
        i_op = op; i_a = a; i_b = b; i_start = 1'b1;
        if (push) begin
            e.hi = eh; e.lo = el; e.dz = ez;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Returns #1 after the edge that raised done; cycles counts edges since issue.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles = 0; busy_cnt = 0;
        while (!o_done && cycles < 100) begin
            if (o_busy) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        if (!o_done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc, bc, saved;
        reset_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
        i_cancel = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0; i_wdata = '0;
        n_tests = 0; n_fail = 0;

        repeat (2) @(posedge clk); #1;
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_div_zero", 32'(o_div_zero), 32'd0);
        check("reset_hi", o_hi, 32'd0);
        check("reset_lo", o_lo, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // MULTU max*max with latency and busy-length checks
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        wait_done(cyc, bc);
        check("multu_latency", 32'(cyc), 32'd33);
        check("multu_busy_cycles", 32'(bc), 32'd33);
        check("busy_low_in_done", 32'(o_busy), 32'd0);

        // MULT -3*5, then DIV -7/2 started in the done cycle
        issue(2'b00, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        wait_done(cyc, bc);
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        check("back_to_back_accepted", 32'(o_busy), 32'd1);
        wait_done(cyc, bc);

        // DIV overflow case
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0);
        wait_done(cyc, bc);

        // DIVU by zero, flag sticky, cleared by next start
        issue(2'b11, 32'd100, 32'd0, 1, 32'h00000064, 32'hFFFFFFFF, 1'b1);
        wait_done(cyc, bc);
        check("divz_latency", 32'(cyc), 32'd33);
        repeat (3) @(posedge clk); #1;
        check("div_zero_sticky", 32'(o_div_zero), 32'd1);
        issue(2'b01, 32'd7, 32'd6, 1, 32'd0, 32'd42, 1'b0);
        check("div_zero_cleared", 32'(o_div_zero), 32'd0);
        wait_done(cyc, bc);

        // MTHI/MTLO preload
        i_hi_we = 1'b1; i_wdata = 32'h1234;
        @(posedge clk); #1;
        i_hi_we = 1'b0; i_lo_we = 1'b1; i_wdata = 32'h5678;
        @(posedge clk); #1;
        i_lo_we = 1'b0;
        check("mthi", o_hi, 32'h1234);
        check("mtlo", o_lo, 32'h5678);

        // DIVU cancelled at counter=10, with an MTHI attempt while busy
        saved = done_count;
        issue(2'b11, 32'd1000, 32'd3, 0, '0, '0, 1'b0);
        repeat (10) @(posedge clk); #1;
        i_cancel = 1'b1; i_hi_we = 1'b1; i_wdata = 32'hDEAD;
        @(posedge clk); #1;
        i_cancel = 1'b0; i_hi_we = 1'b0;
        check("cancel_busy", 32'(o_busy), 32'd0);
        check("cancel_hi_kept", o_hi, 32'h1234);
        check("cancel_lo_kept", o_lo, 32'h5678);
        repeat (40) @(posedge clk); #1;
        check("cancel_no_done", 32'(done_count), 32'(saved));

        // cancel in IDLE suppresses start
        i_op = 2'b01; i_a = 32'd2; i_b = 32'd2; i_start = 1'b1; i_cancel = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_cancel = 1'b0;
        check("idle_cancel_blocks_start", 32'(o_busy), 32'd0);

        // start while busy is ignored
        issue(2'b01, 32'd3, 32'd4, 1, 32'd0, 32'd12, 1'b0);
        repeat (5) @(posedge clk); #1;
        i_op = 2'b01; i_a = 32'd100; i_b = 32'd100; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(cyc, bc);
        @(posedge clk); #1;
        check("busy_start_ignored", 32'(o_busy), 32'd0);

        // asynchronous reset mid-CALC
        issue(2'b01, 32'd5, 32'd5, 0, '0, '0, 1'b0);
        repeat (10) @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(o_busy), 32'd0);
        check("async_reset_hi", o_hi, 32'd0);
        check("async_reset_lo", o_lo, 32'd0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        saved = done_count;
        repeat (40) @(posedge clk); #1;
        check("reset_no_done", 32'(done_count), 32'(saved));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
